// File: rtl/matvec3_pkg.sv
// Shared constants, FSM state type and word-select helper for the matvec3 host driver.
package matvec3_pkg;

  localparam int WIDTH     = 14;
  localparam int OUT_WIDTH = 28;
  localparam int N         = 3;
  localparam int NN        = N * N;
  localparam int CW        = $clog2(NN);
  localparam int RW        = $clog2(N);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_W = 3'd1,
    SEND_X = 3'd2,
    RECV   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Picks word idx out of a packed bus; vectors are zero-extended to matrix width by the caller.
  function automatic logic [WIDTH-1:0] word_sel(input logic [NN*WIDTH-1:0] bus,
                                                input logic [CW-1:0]       idx);
    return bus[idx*WIDTH +: WIDTH];
  endfunction

endpackage

// File: rtl/matvec3_host_driver_up_counter.sv
// Up counter with synchronous reset, clear (priority over enable) and enable.
module up_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/matvec3_host_driver.sv
// Serializes a packed matrix/vector job onto the accelerator input stream and
// gathers the N row results into one packed result vector; one job in flight at a time.
module matvec3_host_driver
  import matvec3_pkg::*;
#(
  parameter int WIDTH     = matvec3_pkg::WIDTH,
  parameter int OUT_WIDTH = matvec3_pkg::OUT_WIDTH,
  parameter int N         = matvec3_pkg::N
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic                   job_new_matrix,
  input  logic [N*N*WIDTH-1:0]   job_matrix,
  input  logic [N*WIDTH-1:0]     job_vector,
  output logic                   acc_in_valid,
  input  logic                   acc_in_ready,
  output logic [WIDTH-1:0]       acc_in_data,
  output logic                   acc_new_matrix,
  input  logic                   acc_out_valid,
  output logic                   acc_out_ready,
  input  logic [OUT_WIDTH-1:0]   acc_out_data,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [N*OUT_WIDTH-1:0] result_vec
);

  state_t state, state_nxt;

  logic [N*N*WIDTH-1:0]   w_reg;
  logic [N*WIDTH-1:0]     x_reg;
  logic [N*N*WIDTH-1:0]   x_ext;
  logic [N*OUT_WIDTH-1:0] y_reg;
  logic                   eff_new;
  logic                   matrix_loaded;

  logic [CW-1:0] cnt;
  logic [RW-1:0] rcnt;

  logic job_acc, in_xfer, out_xfer;
  logic w_last, x_last, r_last;
  logic cnt_clr, cnt_en, rcnt_clr, rcnt_en;

  assign job_acc  = job_valid & job_ready;
  assign in_xfer  = acc_in_valid & acc_in_ready;
  assign out_xfer = acc_out_valid & acc_out_ready;

  assign w_last = (state == SEND_W) && (cnt == CW'(N*N-1));
  assign x_last = (state == SEND_X) && (cnt == CW'(N-1));
  assign r_last = (rcnt == RW'(N-1));

  assign cnt_clr  = in_xfer & (w_last | x_last);
  assign cnt_en   = in_xfer & ~(w_last | x_last);
  assign rcnt_clr = out_xfer & r_last;
  assign rcnt_en  = out_xfer & ~r_last;

  assign x_ext = {{((N*N-N)*WIDTH){1'b0}}, x_reg};

  up_counter #(.W(CW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .q     (cnt)
  );

  up_counter #(.W(RW)) u_rcnt (
    .clk   (clk),
    .reset (reset),
    .clr   (rcnt_clr),
    .en    (rcnt_en),
    .q     (rcnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (job_acc) state_nxt = (job_new_matrix | ~matrix_loaded) ? SEND_W : SEND_X;
      SEND_W:  if (in_xfer && w_last) state_nxt = SEND_X;
      SEND_X:  if (in_xfer && x_last) state_nxt = RECV;
      RECV:    if (out_xfer && r_last) state_nxt = DONE;
      DONE:    if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_reg         <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
      eff_new       <= 1'b0;
      matrix_loaded <= 1'b0;
    end else begin
      if (job_acc) begin
        w_reg   <= job_matrix;
        x_reg   <= job_vector;
        eff_new <= job_new_matrix | ~matrix_loaded;
      end
      if (in_xfer && w_last) begin
        matrix_loaded <= 1'b1;
      end
      if (out_xfer) begin
        y_reg[rcnt*OUT_WIDTH +: OUT_WIDTH] <= acc_out_data;
      end
    end
  end

  // Stream outputs decode only registered state, so they hold steady across stalls.
  always_comb begin
    job_ready      = 1'b0;
    acc_in_valid   = 1'b0;
    acc_in_data    = '0;
    acc_new_matrix = 1'b0;
    acc_out_ready  = 1'b0;
    result_valid   = 1'b0;
    case (state)
      IDLE:   job_ready = 1'b1;
      SEND_W: begin
        acc_in_valid   = 1'b1;
        acc_in_data    = word_sel(w_reg, cnt);
        acc_new_matrix = 1'b1;
      end
      SEND_X: begin
        acc_in_valid   = 1'b1;
        acc_in_data    = word_sel(x_ext, cnt);
        acc_new_matrix = eff_new;
      end
      RECV:    acc_out_ready = 1'b1;
      DONE:    result_valid  = 1'b1;
      default: ;
    endcase
  end

  assign result_vec = y_reg;

endmodule
